// File: rtl/loop_step_pkg.sv
// Shared state and trace-event encodings for loop_step_engine.
package loop_step_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_INC_A = 2'd0,
    EV_INC_B = 2'd1,
    EV_BREAK = 2'd2
  } ev_t;

endpackage

// File: rtl/loop_step_engine.sv
// One-iteration-per-cycle bounded accumulate loop with continue/break control.
// Optional trace port (ev, ev_vld) enabled by defining LOOP_STEP_ENGINE_TRACE_EN.
module loop_step_engine
  import loop_step_pkg::*;
#(
  parameter int W       = 32,
  parameter int ITERS   = 15,
  parameter int A_LIMIT = 100,
  parameter int B_LIMIT = 10,
  parameter int A_STEP  = 10,
  parameter int B_STEP  = 5,
  localparam int IW     = (ITERS > 0) ? $clog2(ITERS + 1) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                brk,
  output logic signed [W-1:0] a,
  output logic signed [W-1:0] b,
  output logic [IW-1:0]       iter
`ifdef LOOP_STEP_ENGINE_TRACE_EN
  ,
  output logic [1:0]          ev,
  output logic                ev_vld
`endif
);

  localparam logic [IW-1:0]       ITERS_C  = IW'(ITERS);
  localparam logic signed [W-1:0] A_LIM_C  = W'(A_LIMIT);
  localparam logic signed [W-1:0] B_LIM_C  = W'(B_LIMIT);
  localparam logic signed [W-1:0] A_STEP_C = W'(A_STEP);
  localparam logic signed [W-1:0] B_STEP_C = W'(B_STEP);

  // Two's-complement wrap: overflow silently discards the carry.
  function automatic logic signed [W-1:0] add_wrap(input logic signed [W-1:0] x,
                                                   input logic signed [W-1:0] y);
    return x + y;
  endfunction

  state_t                r_state;
  logic signed [W-1:0]   r_a;
  logic signed [W-1:0]   r_b;
  logic [IW-1:0]         r_iter;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_brk;

  logic                  w_last;
  logic                  w_a_over;
  logic                  w_b_over;
  logic [IW-1:0]         w_iter_nxt;
  logic                  w_fin;

  assign w_last     = (r_iter == ITERS_C);
  assign w_a_over   = (r_a > A_LIM_C);
  assign w_b_over   = (r_b > B_LIM_C);
  assign w_iter_nxt = r_iter + 1'b1;
  // The iteration that breaks or reaches the bound ends the run on the same edge.
  assign w_fin      = (w_a_over && w_b_over) || (w_iter_nxt == ITERS_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= '0;
            r_b     <= '0;
            r_iter  <= '0;
            r_brk   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_iter <= w_iter_nxt;
            if (w_a_over && w_b_over) begin
              r_brk <= 1'b1;
            end else if (w_a_over) begin
              r_b <= add_wrap(r_b, B_STEP_C);
            end else begin
              r_a <= add_wrap(r_a, A_STEP_C);
            end
            if (w_fin) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign brk  = r_brk;
  assign a    = r_a;
  assign b    = r_b;
  assign iter = r_iter;

`ifdef LOOP_STEP_ENGINE_TRACE_EN
  // Trace decodes the iteration being executed in the current RUN cycle.
  always_comb begin
    ev     = EV_INC_A;
    ev_vld = 1'b0;
    if (r_state == RUN && !w_last) begin
      ev_vld = 1'b1;
      if (w_a_over && w_b_over) ev = EV_BREAK;
      else if (w_a_over)        ev = EV_INC_B;
      else                      ev = EV_INC_A;
    end
  end
`endif

endmodule

// File: tb/tb_loop_step_engine.sv
// Scoreboard bench for loop_step_engine: three instances (ITERS=15, 13, 0).
module tb_loop_step_engine;

  typedef struct {
    longint a;
    longint b;
    longint brk;
    longint iter;
    longint cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st15 = 1'b0, st13 = 1'b0, st0 = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic               busy15, done15, brk15;
  logic signed [31:0] a15, b15;
  logic [3:0]         it15;
  logic               busy13, done13, brk13;
  logic signed [31:0] a13, b13;
  logic [3:0]         it13;
  logic               busy0, done0, brk0;
  logic signed [31:0] a0, b0;
  logic [0:0]         it0;
`ifdef LOOP_STEP_ENGINE_TRACE_EN
  logic [1:0] ev15, ev13, ev0;
  logic       evv15, evv13, evv0;
`endif

  exp_t q15[$];
  exp_t q13[$];
  exp_t q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  loop_step_engine #(.ITERS(15)) d15 (
    .clk(clk), .rst(rst), .start(st15), .busy(busy15), .done(done15), .brk(brk15),
    .a(a15), .b(b15), .iter(it15)
`ifdef LOOP_STEP_ENGINE_TRACE_EN
    , .ev(ev15), .ev_vld(evv15)
`endif
  );

  loop_step_engine #(.ITERS(13)) d13 (
    .clk(clk), .rst(rst), .start(st13), .busy(busy13), .done(done13), .brk(brk13),
    .a(a13), .b(b13), .iter(it13)
`ifdef LOOP_STEP_ENGINE_TRACE_EN
    , .ev(ev13), .ev_vld(evv13)
`endif
  );

  loop_step_engine #(.ITERS(0)) d0 (
    .clk(clk), .rst(rst), .start(st0), .busy(busy0), .done(done0), .brk(brk0),
    .a(a0), .b(b0), .iter(it0)
`ifdef LOOP_STEP_ENGINE_TRACE_EN
    , .ev(ev0), .ev_vld(evv0)
`endif
  );

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=done_pulse required=no_done (cycle %0d)", nm, cyc);
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done15) begin
      if (q15.size() == 0) unexpected("d15_extra_done");
      else begin
        e = q15.pop_front();
        chk("d15_a", a15, e.a);
        chk("d15_b", b15, e.b);
        chk("d15_brk", brk15, e.brk);
        chk("d15_iter", it15, e.iter);
        chk("d15_done_cycle", cyc, e.cyc);
        chk("d15_busy_at_done", busy15, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done13) begin
      if (q13.size() == 0) unexpected("d13_extra_done");
      else begin
        e = q13.pop_front();
        chk("d13_a", a13, e.a);
        chk("d13_b", b13, e.b);
        chk("d13_brk", brk13, e.brk);
        chk("d13_iter", it13, e.iter);
        chk("d13_done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done0) begin
      if (q0.size() == 0) unexpected("d0_extra_done");
      else begin
        e = q0.pop_front();
        chk("d0_a", a0, e.a);
        chk("d0_b", b0, e.b);
        chk("d0_brk", brk0, e.brk);
        chk("d0_iter", it0, e.iter);
        chk("d0_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Pulse start for one cycle on instance sel; cycle t is the one whose closing edge samples it.
  task automatic go(input int sel, input bit push, input longint ea, input longint eb,
                    input longint ebrk, input longint eit, input int lat, output int t);
    exp_t e;
    @(posedge clk); #1;
    t = cyc;
    e.a = ea; e.b = eb; e.brk = ebrk; e.iter = eit; e.cyc = t + lat;
    case (sel)
      15: begin st15 = 1'b1; if (push) q15.push_back(e); end
      13: begin st13 = 1'b1; if (push) q13.push_back(e); end
      default: begin st0 = 1'b1; if (push) q0.push_back(e); end
    endcase
    @(posedge clk); #1;
    st15 = 1'b0; st13 = 1'b0; st0 = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q15.size() + q13.size() + q0.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if ((q15.size() + q13.size() + q0.size()) != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", q15.size() + q13.size() + q0.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    exp_t e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a", a15, 0);
    chk("rst_b", b15, 0);
    chk("rst_iter", it15, 0);
    chk("rst_busy", busy15, 0);
    chk("rst_done", done15, 0);
    chk("rst_brk", brk15, 0);

    // Defaults: 11 x inc a, 3 x inc b, break on iteration 15.
    go(15, 1, 110, 15, 1, 15, 16, t);
    @(negedge clk);
    chk("d15_busy_in_run", busy15, 1);
    wait_drain();
    chk("d15_hold_a_idle", a15, 110);
    chk("d15_hold_brk_idle", brk15, 1);

    // ITERS=13: natural end with no break.
    go(13, 1, 110, 10, 0, 13, 14, t);
    wait_drain();

    // ITERS=0: empty run.
    go(0, 1, 0, 0, 0, 0, 2, t);
    wait_drain();

    // start held 30 cycles: one run, then a second accepted at the first IDLE cycle.
    @(posedge clk); #1;
    t = cyc;
    st15 = 1'b1;
    e.a = 110; e.b = 15; e.brk = 1; e.iter = 15; e.cyc = t + 16;
    q15.push_back(e);
    e.cyc = t + 33;
    q15.push_back(e);
    repeat (30) @(posedge clk);
    #1;
    st15 = 1'b0;
    wait_drain();

    // Reset mid-run aborts without a done pulse.
    go(15, 0, 0, 0, 0, 0, 0, t);
    while (cyc < t + 5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_a", a15, 0);
    chk("abort_b", b15, 0);
    chk("abort_busy", busy15, 0);
    chk("abort_done", done15, 0);
    repeat (20) @(posedge clk);
    #1;
    go(15, 1, 110, 15, 1, 15, 16, t);
    wait_drain();

    chk("queues_empty", q15.size() + q13.size() + q0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/loop_step_engine.md
Name: loop_step_engine

Overview:
- Clocked, one-iteration-per-cycle execution of a bounded accumulate loop with break/continue control:
  - Up to ITERS iterations.
  - While a <= A_LIMIT, add A_STEP to a.
  - Once a > A_LIMIT, add B_STEP to b ("continue"), or terminate early when b > B_LIMIT ("break").
- Sits directly downstream of the elaboration-time loop tests. It produces the same a/b results at run time, behind a start/done handshake, so synthesized hardware can be compared against the initial-block reference values.

Parameters:
- W, 32, data width of a and b; signed.
- ITERS, 15, maximum iteration count; 0 allowed.
- A_LIMIT, 100, signed threshold on a.
- B_LIMIT, 10, signed threshold on b; break condition.
- A_STEP, 10, signed increment applied to a.
- B_STEP, 5, signed increment applied to b.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a run; accepted only in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run ends.
- brk  out  1  high if the last run ended by break; held until next accepted start.
- a  out  W  signed accumulator a.
- b  out  W  signed accumulator b.
- iter  out  $clog2(ITERS+1) (min 1)  iterations executed in current/last run.

Behaviour:
- Reset: state=IDLE; a=0, b=0, iter=0, busy=0, done=0, brk=0. Reset asserted mid-RUN aborts the run with no done pulse.
- States:
  - IDLE: start=1 sets a=0, b=0, iter=0, brk=0, then goes to RUN.
  - RUN: one iteration per cycle. If iter==ITERS, go to DONE with no update. Otherwise:
    - a > A_LIMIT and b > B_LIMIT: brk=1, iter+1, go to DONE; a and b unchanged.
    - a > A_LIMIT and b <= B_LIMIT: b += B_STEP, iter+1, stay in RUN (continue).
    - otherwise: a += A_STEP, iter+1, stay in RUN.
    - The iteration that reaches iter==ITERS moves straight to DONE on that same edge; no extra empty RUN cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start while in RUN or DONE is ignored and not queued.
- ITERS=0: RUN lasts one cycle with no update; done pulses at start_cycle+2; a=b=0.
- Latency: start sampled at edge t. With k = iterations executed (including a breaking iteration), done is high in cycle t+k+1.
- Outputs a, b, iter and brk hold their values in IDLE until the next accepted start.
- Arithmetic: signed W-bit, wraps modulo 2^W with no saturation. Comparisons are signed and strict (>).

Optional Feature:
- Macro LOOP_STEP_ENGINE_TRACE_EN.
  - Defined: adds output port ev (2 bits) and ev_vld (1 bit). ev_vld=1 in each RUN cycle that executes an iteration. ev codes: 0=INC_A, 1=INC_B (continue), 2=BREAK. Both outputs reset to 0.
  - Undefined: neither port exists; core behaviour is identical.

Decomposition:
- Package loop_step_pkg:
  - state enum: IDLE, RUN, DONE.
  - event enum: EV_INC_A, EV_INC_B, EV_BREAK.
- Single module, no sub-module: the datapath (two adders, two comparators) is too small to split.

Test Plan:
- Defaults, start pulse at t → inc a ×11, inc b ×3 (b 5, 10, 15), break on iteration 15. done at t+16 with a=110, b=15, brk=1, iter=15.
- ITERS=13, other defaults → natural end, done at t+14 with a=110, b=10, brk=0, iter=13.
- ITERS=0 → done at t+2, a=0, b=0, brk=0, iter=0.
- start held high for 30 cycles (defaults) → exactly one run: done once at t+16, then a second run accepted at the first IDLE cycle with start=1.
- rst asserted at t+5 mid-run → next cycle IDLE, a=0, b=0, busy=0, no done pulse. Fresh start then reproduces a=110, b=15.
- TRACE_EN defined, defaults → ev_vld high 15 cycles; ev sequence is 11×INC_A, 3×INC_B, 1×BREAK.
